noc_demux_1ton_reg: RTL and testbench
=====================================

Name: noc_demux_1ton_reg

Overview:
- Parametrised, registered successor to the NoC router's 1-to-5 output demux.
- Steers one input flit stream to one of NUM_PORTS output channels (default 5: N, S, W, E, L).
- Each channel carries valid/ready flow control and a one-flit holding register.
- Sits between the router's route-compute stage and the per-direction output links. Unselected or idle outputs never float and never drive X.

Parameters:
- DATA_W, 16, flit width in bits.
- NUM_PORTS, 5, number of output channels (2..8).
- SEL_W, $clog2(NUM_PORTS), localparam; width of the select field.
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- data_i  input  DATA_W  incoming flit.
- sel_i  input  SEL_W  destination port index; valid range 0..NUM_PORTS-1.
- valid_i  input  1  flit on data_i/sel_i is valid.
- ready_o  output  1  block accepts the flit this cycle.
- data_o  output  NUM_PORTS*DATA_W  per-port flit; port p occupies bits [p*DATA_W +: DATA_W].
- valid_o  output  NUM_PORTS  per-port valid.
- ready_i  input  NUM_PORTS  per-port downstream ready.
- drop_o  output  1  one-cycle pulse when a flit with out-of-range sel_i is discarded.
- drop_cnt_o  output  DROP_CNT_W  saturating count of dropped flits.

Behaviour:
- Reset (sync, rst_ni=0 sampled at clock edge):
  - all holding registers emptied: valid_o=0.
  - data_o = 0, drop_o = 0, drop_cnt_o = 0.
  - Flits held at reset are discarded, including a reset asserted mid-transfer.
- Per-port state: EMPTY (valid_o[p]=0) or FULL (valid_o[p]=1).
  - EMPTY->FULL on accept to p.
  - FULL->EMPTY on valid_o[p]&&ready_i[p] with no accept to p.
  - FULL->FULL on drain and accept to p in the same cycle; the new flit replaces the old one.
- ready_o:
  - sel_i in range: ready_o = !valid_o[sel_i] || ready_i[sel_i].
  - sel_i out of range: ready_o = 1.
  - ready_o does not depend on valid_i.
- Accept = valid_i && ready_o.
  - In range: the flit is registered into port sel_i. valid_o rises the next cycle, so latency is 1 cycle.
  - Out of range: the flit is dropped, drop_o pulses the next cycle, and drop_cnt_o increments, saturating at 2^DROP_CNT_W-1.
- Independent ports: a stalled port never blocks accepts to other ports; other ports keep draining regardless.
- data_o[p] holds its last value while EMPTY; no X or Z is ever driven.
- A FULL port holds data_o and valid_o stable until ready_i[p] is seen (AXI-style; no retraction).
- Full throughput: one flit/cycle to a single port while ready_i stays high.
- Only one port is loaded per cycle.

Optional Feature:
- Macro: NOC_DEMUX_STATS_EN.
- Defined: adds output fwd_cnt_o [15:0], a wrapping count of flits delivered (sum over p of valid_o[p]&&ready_i[p] per cycle, at most NUM_PORTS per cycle). Reset to 0.
- Undefined: the port is absent and no counter logic is built. All other behaviour is identical.

Decomposition:
- Shared package noc_pkg:
  - DATA_W default constant.
  - Port index enum port_e: PORT_N=0, PORT_S=1, PORT_W=2, PORT_E=3, PORT_L=4.
  - NUM_DIRS=5.
- Sub-module noc_out_slot: one-flit holding register with valid/ready. It is instantiated NUM_PORTS times via generate, and the top contains only the select decode, ready mux and drop counter.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with valid_i=1 → valid_o=5'b0, data_o=0, drop_cnt_o=0, ready_o=1.
- Routing: send 0xA001..0xA005 with sel 0..4, all ready_i=1 → each appears on its own port exactly 1 cycle after accept, with a single valid bit.
- Back-pressure: ready_i[2]=0, send 0x1111 then 0x2222 to sel=2 → the second flit sees ready_o=0; port 2 holds 0x1111 stable. Raise ready_i[2] → 0x1111 drains and 0x2222 loads in the same cycle.
- Independence: port 3 is stalled FULL; send 0xBEEF to sel=4 → accepted immediately and delivered on port 4 next cycle.
- Drop: send sel=5, 6, 7 (NUM_PORTS=5) → ready_o=1, three drop_o pulses, drop_cnt_o=3, valid_o unchanged. Then 300 bad flits → drop_cnt_o=255.
- Stats (NOC_DEMUX_STATS_EN): 10 flits spread over 5 ports with all ready_i=1 → fwd_cnt_o=10. Reset mid-burst → fwd_cnt_o=0 and all valid_o=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit width, router direction indices and
// the per-slot holding-register state encoding.
package noc_pkg;

    localparam int NOC_DATA_W = 16;
    localparam int NUM_DIRS   = 5;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_W = 3'd2,
        PORT_E = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/noc_out_slot.sv
// One-flit output holding register with valid/ready handshake.
// state      | meaning
// SLOT_EMPTY | no flit held, valid_o=0, data_o keeps last flit
// SLOT_FULL  | flit held and presented until ready_i is seen
module noc_out_slot
    import noc_pkg::*;
#(
    parameter int DATA_W = NOC_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    slot_state_e       r_state;
    slot_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (load_i) begin
                r_data <= data_i;
            end
        end
    end

    // Drain and reload in the same cycle keeps the slot FULL with the new flit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (load_i) w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (!load_i && ready_i) w_state_nxt = SLOT_EMPTY;
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end

    assign ready_o = (r_state == SLOT_EMPTY) || ready_i;
    assign valid_o = (r_state == SLOT_FULL);
    assign data_o  = r_data;

endmodule

// File: rtl/noc_demux_1ton_reg.sv
// Registered 1-to-N flit demux with per-port holding slots and a saturating
// drop counter. Optional macro NOC_DEMUX_STATS_EN adds a delivered-flit counter.
module noc_demux_1ton_reg
    import noc_pkg::*;
#(
    parameter  int DATA_W     = NOC_DATA_W,
    parameter  int NUM_PORTS  = NUM_DIRS,
    parameter  int DROP_CNT_W = 8,
    localparam int SEL_W      = $clog2(NUM_PORTS)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [DATA_W-1:0]           data_i,
    input  logic [SEL_W-1:0]            sel_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [NUM_PORTS*DATA_W-1:0] data_o,
    output logic [NUM_PORTS-1:0]        valid_o,
    input  logic [NUM_PORTS-1:0]        ready_i,
    output logic                        drop_o,
`ifdef NOC_DEMUX_STATS_EN
    output logic [15:0]                 fwd_cnt_o,
`endif
    output logic [DROP_CNT_W-1:0]       drop_cnt_o
);

    logic [NUM_PORTS-1:0]  w_slot_ready;
    logic [NUM_PORTS-1:0]  w_load;
    logic                  w_in_range;
    logic                  w_ready;
    logic                  w_drop;
    logic                  r_drop;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    assign w_in_range = ({1'b0, sel_i} < (SEL_W+1)'(NUM_PORTS));

    // Out-of-range selects match no slot, so ready defaults to 1 for them.
    always_comb begin
        w_ready = 1'b1;
        w_load  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sel_i == SEL_W'(p)) begin
                w_ready = w_slot_ready[p];
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_load[p] = valid_i && w_ready && (sel_i == SEL_W'(p));
        end
    end

    assign ready_o = w_ready;
    assign w_drop  = valid_i && !w_in_range;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
        noc_out_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .load_i  (w_load[g]),
            .data_i  (data_i),
            .ready_i (ready_i[g]),
            .ready_o (w_slot_ready[g]),
            .valid_o (valid_o[g]),
            .data_o  (data_o[g*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_drop <= w_drop;
            if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign drop_o     = r_drop;
    assign drop_cnt_o = r_drop_cnt;

`ifdef NOC_DEMUX_STATS_EN
    logic [15:0] w_fwd_inc;
    logic [15:0] r_fwd_cnt;

    always_comb begin
        w_fwd_inc = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_fwd_inc = w_fwd_inc + 16'(valid_o[p] & ready_i[p]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fwd_cnt <= '0;
        end else begin
            r_fwd_cnt <= r_fwd_cnt + w_fwd_inc;
        end
    end

    assign fwd_cnt_o = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_noc_demux_1ton_reg.sv
// Directed self-checking bench for noc_demux_1ton_reg (default 5 ports, 16-bit
// flits); the stats test is compiled in when NOC_DEMUX_STATS_EN is defined.
module tb_noc_demux_1ton_reg;

    localparam int DW = 16;
    localparam int NP = 5;

    logic           clk;
    logic           rst_n;
    logic [DW-1:0]  data_in;
    logic [2:0]     sel;
    logic           vin;
    logic           rdy_out;
    logic [NP*DW-1:0] dout;
    logic [NP-1:0]  vout;
    logic [NP-1:0]  rdy_in;
    logic           drop;
    logic [7:0]     drop_cnt;
`ifdef NOC_DEMUX_STATS_EN
    logic [15:0]    fwd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    noc_demux_1ton_reg dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .data_i     (data_in),
        .sel_i      (sel),
        .valid_i    (vin),
        .ready_o    (rdy_out),
        .data_o     (dout),
        .valid_o    (vout),
        .ready_i    (rdy_in),
        .drop_o     (drop),
`ifdef NOC_DEMUX_STATS_EN
        .fwd_cnt_o  (fwd_cnt),
`endif
        .drop_cnt_o (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] port_data(input int p);
        return dout[p*DW +: DW];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; vin = 1'b1; sel = 3'd0; data_in = 16'h1234; rdy_in = '1;
        tick(); tick();
        checks++; if (vout !== 5'b0) begin errors++; $display("FAIL reset_valid: got %b want 00000", vout); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", dout); end
        checks++; if (drop_cnt !== 8'd0 || drop !== 1'b0) begin errors++; $display("FAIL reset_drop: cnt %0d drop %b want 0 0", drop_cnt, drop); end
        checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy_out); end
        vin = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_routing();
        rdy_in = '1;
        for (int i = 0; i < NP; i++) begin
            data_in = 16'hA001 + 16'(i); sel = 3'(i); vin = 1'b1;
            #1;
            checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL route_ready[%0d]: got %b want 1", i, rdy_out); end
            tick();
            checks++; if (vout !== 5'(1 << i)) begin errors++; $display("FAIL route_valid[%0d]: got %b want %b", i, vout, 5'(1 << i)); end
            checks++; if (port_data(i) !== 16'hA001 + 16'(i)) begin errors++; $display("FAIL route_data[%0d]: got %h want %h", i, port_data(i), 16'hA001 + 16'(i)); end
        end
        vin = 1'b0;
        tick();
        checks++; if (vout !== 5'b0) begin errors++; $display("FAIL route_idle: got %b want 00000", vout); end
        checks++; if (port_data(4) !== 16'hA005) begin errors++; $display("FAIL route_hold: got %h want a005", port_data(4)); end
    endtask

    task automatic test_back_to_back();
        rdy_in = 5'b11011;
        data_in = 16'h1111; sel = 3'd2; vin = 1'b1;
        tick();
        data_in = 16'h2222;
        #1;
        checks++; if (rdy_out !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", rdy_out); end
        tick(); tick();
        checks++; if (vout[2] !== 1'b1 || port_data(2) !== 16'h1111) begin errors++; $display("FAIL bp_hold: valid %b data %h want 1 1111", vout[2], port_data(2)); end
        rdy_in = 5'b11111;
        #1;
        checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL bp_ready_high: got %b want 1", rdy_out); end
        tick();
        checks++; if (vout !== 5'b00100 || port_data(2) !== 16'h2222) begin errors++; $display("FAIL bp_reload: valid %b data %h want 00100 2222", vout, port_data(2)); end
        vin = 1'b0;
        tick();
        checks++; if (vout !== 5'b0) begin errors++; $display("FAIL bp_drain: got %b want 00000", vout); end
    endtask

    task automatic test_independence();
        rdy_in = 5'b10111;
        data_in = 16'h3333; sel = 3'd3; vin = 1'b1;
        tick();
        data_in = 16'hBEEF; sel = 3'd4;
        #1;
        checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL indep_ready: got %b want 1", rdy_out); end
        tick();
        checks++; if (vout !== 5'b11000 || port_data(4) !== 16'hBEEF || port_data(3) !== 16'h3333) begin
            errors++; $display("FAIL indep_deliver: valid %b p4 %h p3 %h want 11000 beef 3333", vout, port_data(4), port_data(3)); end
        vin = 1'b0;
        tick();
        checks++; if (vout !== 5'b01000) begin errors++; $display("FAIL indep_drain: got %b want 01000", vout); end
    endtask

    task automatic test_drop();
        for (int i = 5; i < 8; i++) begin
            data_in = 16'hDEAD; sel = 3'(i); vin = 1'b1;
            #1;
            checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL drop_ready[%0d]: got %b want 1", i, rdy_out); end
            tick();
            checks++; if (drop !== 1'b1 || drop_cnt !== 8'(i - 4)) begin errors++; $display("FAIL drop_pulse[%0d]: drop %b cnt %0d want 1 %0d", i, drop, drop_cnt, i - 4); end
            checks++; if (vout !== 5'b01000) begin errors++; $display("FAIL drop_valid[%0d]: got %b want 01000", i, vout); end
        end
        vin = 1'b0;
        tick();
        checks++; if (drop !== 1'b0 || drop_cnt !== 8'd3) begin errors++; $display("FAIL drop_idle: drop %b cnt %0d want 0 3", drop, drop_cnt); end
        vin = 1'b1; sel = 3'd7;
        repeat (251) tick();
        checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL drop_254: got %0d want 254", drop_cnt); end
        repeat (49) tick();
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
        vin = 1'b0; rdy_in = '1;
        tick();
        checks++; if (vout !== 5'b0 || drop !== 1'b0) begin errors++; $display("FAIL drop_release: valid %b drop %b want 00000 0", vout, drop); end
    endtask

    task automatic test_reset_mid();
        rdy_in = 5'b11110;
        data_in = 16'h5A5A; sel = 3'd0; vin = 1'b1;
        tick();
        checks++; if (vout !== 5'b00001) begin errors++; $display("FAIL mid_load: got %b want 00001", vout); end
        rst_n = 1'b0;
        tick();
        checks++; if (vout !== 5'b0 || dout !== '0 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL mid_reset: valid %b data %h cnt %0d want 0 0 0", vout, dout, drop_cnt); end
        rst_n = 1'b1; vin = 1'b0; rdy_in = '1;
        tick();
    endtask

`ifdef NOC_DEMUX_STATS_EN
    task automatic test_stats();
        rdy_in = '1;
        checks++; if (fwd_cnt !== 16'd0) begin errors++; $display("FAIL stats_start: got %0d want 0", fwd_cnt); end
        for (int i = 0; i < 10; i++) begin
            data_in = 16'h0100 + 16'(i); sel = 3'(i % NP); vin = 1'b1;
            tick();
        end
        vin = 1'b0;
        tick(); tick();
        checks++; if (fwd_cnt !== 16'd10) begin errors++; $display("FAIL stats_count: got %0d want 10", fwd_cnt); end
        for (int i = 0; i < 3; i++) begin
            sel = 3'(i); vin = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        checks++; if (fwd_cnt !== 16'd0 || vout !== 5'b0) begin errors++; $display("FAIL stats_reset: cnt %0d valid %b want 0 00000", fwd_cnt, vout); end
        rst_n = 1'b1; vin = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst_n = 1'b0; vin = 1'b0; sel = '0; data_in = '0; rdy_in = '1;
        test_reset();
        test_routing();
        test_back_to_back();
        test_independence();
        test_drop();
        test_reset_mid();
`ifdef NOC_DEMUX_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
